multicycle_control_fsm: RTL and testbench
=========================================

Name: multicycle_control_fsm

Overview:
Control sequencer for the multi-cycle RISC-V core variant. The core shares one ALU and one unified instruction/data memory port across several cycles per instruction. This block walks each instruction through fetch/decode/execute/memory/writeback states and drives every datapath mux select and write enable. It also adds a MemReady wait handshake so the core tolerates slow memory.

Parameters:
TRAP_ON_ILLEGAL, 1, 1: an unsupported opcode enters TRAP and stays there until reset; 0: treat it as a NOP and return to FETCH.
STATE_W, 4, width of the state register and the State debug port.

Ports:
clk  input  1  core clock; all state changes on the rising edge
reset  input  1  synchronous, active-high; clears the FSM to FETCH
op  input  7  opcode field, taken from the instruction register
funct3  input  3  instruction funct3
funct7  input  7  instruction funct7; only bit 5 is used
Zero  input  1  ALU zero flag
MemReady  input  1  memory has completed the current access this cycle
MemReq  output  1  memory access active (FETCH, MEMREAD, MEMWRITE)
PCWrite  output  1  PC register enable
AdrSrc  output  1  memory address select: 0 = PC, 1 = Result
MemWrite  output  1  data memory write strobe
IRWrite  output  1  instruction register and OldPC enable
ResultSrc  output  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult
ALUSrcA  output  2  ALU A select: 00 = PC, 01 = OldPC, 10 = RegA
ALUSrcB  output  2  ALU B select: 00 = RegB, 01 = ImmExt, 10 = constant 4
ALUControl  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt
ImmSrc  output  3  immediate type: 000 I, 001 S, 010 B, 011 J
RegWrite  output  1  register file write enable
Trap  output  1  illegal instruction detected; sticky until reset
State  output  STATE_W  current state, for debug

Behaviour:
- State encodings: FETCH = 0, DECODE = 1, MEMADR = 2, MEMREAD = 3, MEMWB = 4, MEMWRITE = 5, EXECR = 6, EXECI = 7, ALUWB = 8, BEQ = 9, JAL = 10, TRAP = 11. Codes 12-15 are unreachable and recover to FETCH on the next edge.
- Outputs are decoded from State, with Zero gating BEQ and MemReady gating the wait states. Any control output not listed for a state is 0.
- Reset:
  - On the edge with reset = 1, State becomes FETCH.
  - While reset is high, PCWrite, IRWrite, MemWrite, RegWrite and MemReq are forced to 0 combinationally.
  - After reset, Trap = 0.
  - Reset mid-instruction abandons the instruction with no further writes.
- FETCH: MemReq = 1, AdrSrc = 0, ALUSrcA = 00, ALUSrcB = 10, ALUOp = add, ResultSrc = 10.
  - IRWrite and PCWrite are 1 only in a cycle where MemReady = 1; that cycle advances to DECODE.
  - While MemReady = 0, stay in FETCH and hold both enables at 0.
- DECODE: ALUSrcA = 01, ALUSrcB = 01, ALUControl = add (branch target goes to ALUOut). ImmSrc is decoded from op. Next state by op:
  - 0000011 (lw) and 0100011 (sw) go to MEMADR.
  - 0110011 goes to EXECR.
  - 0010011 goes to EXECI.
  - 1100011 goes to BEQ.
  - 1101111 goes to JAL.
  - Any other op goes to TRAP if TRAP_ON_ILLEGAL = 1, else FETCH.
- MEMADR: ALUSrcA = 10, ALUSrcB = 01, add. Next is MEMREAD if op[5] = 0, MEMWRITE if op[5] = 1.
- MEMREAD: MemReq = 1, AdrSrc = 1, ResultSrc = 00. Wait while MemReady = 0; go to MEMWB when MemReady = 1.
- MEMWB: ResultSrc = 01, RegWrite = 1, then FETCH.
- MEMWRITE: MemReq = 1, AdrSrc = 1, ResultSrc = 00, MemWrite = 1 held throughout the wait. Go to FETCH in the cycle MemReady = 1.
- EXECR and EXECI: ALUSrcA = 10; ALUSrcB = 00 for R-type, 01 for I-type. ALU ops are decoded from funct3 (see ALU decode). Next is ALUWB.
- ALUWB: ResultSrc = 00, RegWrite = 1, then FETCH.
- BEQ: ALUSrcA = 10, ALUSrcB = 00, sub, ResultSrc = 00. PCWrite = Zero. Next is FETCH whether or not the branch is taken.
- JAL: ALUSrcA = 01, ALUSrcB = 10, add, ResultSrc = 00, PCWrite = 1. Next is ALUWB, so rd receives PC+4.
- TRAP: all enables 0, Trap = 1. Remains in TRAP until reset.
- ALU decode for ALUOp = funct:
  - funct3 000 gives sub only when op[5] = 1 and funct7[5] = 1; otherwise add. addi therefore never subtracts.
  - funct3 010 gives slt, 110 gives or, 111 gives and.
  - Any other funct3 gives add.
- Latency with MemReady tied to 1: lw 5 cycles, sw 4, R-type and I-type 4, beq 3, jal 4. Each MemReady = 0 cycle adds one cycle.

Decomposition:
- Shared package mc_ctrl_pkg holds:
  - the state encodings;
  - opcode constants (OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL);
  - ALUOp codes (add = 00, sub = 01, funct = 10);
  - ALUControl, ImmSrc, ResultSrc, ALUSrcA and ALUSrcB encodings.
- One sub-module, mc_alu_dec: combinational ALUOp/funct3/funct7/op to ALUControl.
- The state register, next-state logic and output decode stay in the top module.

Test Plan:
- lw (op 0000011), MemReady = 1 -> State 0, 1, 2, 3, 4, 0. RegWrite = 1 only in MEMWB, with ResultSrc = 01. IRWrite is high exactly one cycle.
- sw (op 0100011), MemReady low for 2 cycles in MEMWRITE -> MemWrite = 1 for 3 consecutive cycles, MemReq = 1 throughout, then State = 0. Total 6 cycles.
- beq with Zero = 1, then a second beq with Zero = 0 -> PCWrite = 1 in the BEQ cycle of the first only. Both return to FETCH after 3 cycles.
- R-type sub (funct3 000, funct7 0100000) gives ALUControl = 001 in EXECR. addi with funct7 bits = 0100000 gives ALUControl = 000.
- op 1111111 with TRAP_ON_ILLEGAL = 1 -> State = 11, Trap = 1 held for 10+ cycles, all enables 0. Assert reset -> State = 0, Trap = 0.
- Assert reset during MEMWRITE while MemReady = 0 -> MemWrite drops to 0 in the same cycle. Next State = 0. No RegWrite or PCWrite before the next fetch.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle RISC-V control sequencer.
// Holds the state encodings, opcode constants, ALUOp codes, the datapath
// select encodings, and a helper that maps an opcode to its immediate type.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_REGA  = 2'b10;

  localparam logic [1:0] SRCB_REGB = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // R-type has no immediate; it falls back to the I encoding.
  function automatic logic [2:0] imm_src_of(input logic [6:0] op);
    case (op)
      OP_SW:   imm_src_of = IMM_S;
      OP_BEQ:  imm_src_of = IMM_B;
      OP_JAL:  imm_src_of = IMM_J;
      default: imm_src_of = IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/mc_alu_dec.sv
// ALU control decoder.
// Ports:
//   i_alu_op      ALUOp from the sequencer (add / sub / funct)
//   i_funct3      instruction funct3
//   i_op5         opcode bit 5 (1 = R-type, 0 = I-type arithmetic)
//   i_funct7_5    instruction funct7 bit 5
//   o_alu_control ALUControl code driven to the ALU
module mc_alu_dec
  import mc_ctrl_pkg::*;
(
  input  aluop_t     i_alu_op,
  input  logic [2:0] i_funct3,
  input  logic       i_op5,
  input  logic       i_funct7_5,
  output logic [2:0] o_alu_control
);

  always_comb begin
    o_alu_control = ALU_ADD;
    case (i_alu_op)
      ALUOP_ADD: o_alu_control = ALU_ADD;
      ALUOP_SUB: o_alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (i_funct3)
          // addi reuses funct7 bits as immediate, so only R-type may subtract.
          3'b000:  o_alu_control = (i_op5 && i_funct7_5) ? ALU_SUB : ALU_ADD;
          3'b010:  o_alu_control = ALU_SLT;
          3'b110:  o_alu_control = ALU_OR;
          3'b111:  o_alu_control = ALU_AND;
          default: o_alu_control = ALU_ADD;
        endcase
      end
      default: o_alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Control sequencer for the multi-cycle RISC-V core. Walks each instruction
// through fetch/decode/execute/memory/writeback and drives every datapath
// select and write enable, waiting on MemReady for memory accesses.
// Ports:
//   clk, reset        clock; synchronous active-high reset to FETCH
//   op, funct3, funct7 instruction fields (only funct7[5] is used)
//   Zero              ALU zero flag, gates PCWrite in BEQ
//   MemReady          memory access completes this cycle
//   MemReq..RegWrite  datapath selects and enables
//   Trap              illegal instruction seen, sticky until reset
//   State             current state for debug
module multicycle_control_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int TRAP_ON_ILLEGAL = 1,
  parameter int STATE_W         = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [6:0]         op,
  input  logic [2:0]         funct3,
  input  logic [6:0]         funct7,
  input  logic               Zero,
  input  logic               MemReady,
  output logic               MemReq,
  output logic               PCWrite,
  output logic               AdrSrc,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic [1:0]         ResultSrc,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [2:0]         ALUControl,
  output logic [2:0]         ImmSrc,
  output logic               RegWrite,
  output logic               Trap,
  output logic [STATE_W-1:0] State
);

  state_t r_state;
  state_t w_next_state;
  aluop_t w_alu_op;
  logic   w_unused_funct7;

  assign w_unused_funct7 = &{1'b0, funct7[6], funct7[4:0]};

  mc_alu_dec u_alu_dec (
    .i_alu_op      (w_alu_op),
    .i_funct3      (funct3),
    .i_op5         (op[5]),
    .i_funct7_5    (funct7[5]),
    .o_alu_control (ALUControl)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next_state;
  end

  assign State = STATE_W'(r_state);

  always_comb begin
    w_next_state = r_state;
    w_alu_op     = ALUOP_ADD;
    MemReq       = 1'b0;
    PCWrite      = 1'b0;
    AdrSrc       = 1'b0;
    MemWrite     = 1'b0;
    IRWrite      = 1'b0;
    ResultSrc    = RES_ALUOUT;
    ALUSrcA      = SRCA_PC;
    ALUSrcB      = SRCB_REGB;
    ImmSrc       = IMM_I;
    RegWrite     = 1'b0;
    Trap         = 1'b0;

    case (r_state)
      S_FETCH: begin
        MemReq    = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        if (MemReady) begin
          IRWrite      = 1'b1;
          PCWrite      = 1'b1;
          w_next_state = S_DECODE;
        end
      end
      S_DECODE: begin
        // Precompute the branch target into ALUOut.
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = imm_src_of(op);
        case (op)
          OP_LW, OP_SW: w_next_state = S_MEMADR;
          OP_R:         w_next_state = S_EXECR;
          OP_I:         w_next_state = S_EXECI;
          OP_BEQ:       w_next_state = S_BEQ;
          OP_JAL:       w_next_state = S_JAL;
          default:      w_next_state = (TRAP_ON_ILLEGAL != 0) ? S_TRAP : S_FETCH;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA      = SRCA_REGA;
        ALUSrcB      = SRCB_IMM;
        w_next_state = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        MemReq = 1'b1;
        AdrSrc = 1'b1;
        if (MemReady) w_next_state = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc    = RES_DATA;
        RegWrite     = 1'b1;
        w_next_state = S_FETCH;
      end
      S_MEMWRITE: begin
        // Strobe stays asserted for the whole wait so slow memory sees it.
        MemReq   = 1'b1;
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        if (MemReady) w_next_state = S_FETCH;
      end
      S_EXECR: begin
        ALUSrcA      = SRCA_REGA;
        ALUSrcB      = SRCB_REGB;
        w_alu_op     = ALUOP_FUNCT;
        w_next_state = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA      = SRCA_REGA;
        ALUSrcB      = SRCB_IMM;
        w_alu_op     = ALUOP_FUNCT;
        w_next_state = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite     = 1'b1;
        w_next_state = S_FETCH;
      end
      S_BEQ: begin
        ALUSrcA      = SRCA_REGA;
        ALUSrcB      = SRCB_REGB;
        w_alu_op     = ALUOP_SUB;
        PCWrite      = Zero;
        w_next_state = S_FETCH;
      end
      S_JAL: begin
        // PC takes the target from ALUOut while the ALU forms OldPC+4 for rd.
        ALUSrcA      = SRCA_OLDPC;
        ALUSrcB      = SRCB_FOUR;
        PCWrite      = 1'b1;
        w_next_state = S_ALUWB;
      end
      S_TRAP: begin
        Trap         = 1'b1;
        w_next_state = S_TRAP;
      end
      default: w_next_state = S_FETCH;
    endcase

    // Abandon any in-flight instruction immediately, not at the next edge.
    if (reset) begin
      MemReq   = 1'b0;
      PCWrite  = 1'b0;
      MemWrite = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
module tb_multicycle_control_fsm;

  logic       clk;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       Zero;
  logic       MemReady;
  logic       MemReq, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Trap;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0] ALUControl, ImmSrc;
  logic [3:0] State;

  int checks = 0;
  int errors = 0;

  multicycle_control_fsm #(.TRAP_ON_ILLEGAL(1), .STATE_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct3     (funct3),
    .funct7     (funct7),
    .Zero       (Zero),
    .MemReady   (MemReady),
    .MemReq     (MemReq),
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ALUControl (ALUControl),
    .ImmSrc     (ImmSrc),
    .RegWrite   (RegWrite),
    .Trap       (Trap),
    .State      (State)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    reset    = 1'b1;
    op       = 7'b0000011;
    funct3   = 3'b000;
    funct7   = 7'b0000000;
    Zero     = 1'b0;
    MemReady = 1'b1;
    tick();
    tick();
    #1;
    // Reset held in FETCH with MemReady high: enables forced low.
    chk("rst_state", 32'(State), 0);
    chk("rst_memreq", 32'(MemReq), 0);
    chk("rst_irwrite", 32'(IRWrite), 0);
    chk("rst_pcwrite", 32'(PCWrite), 0);
    chk("rst_trap", 32'(Trap), 0);
    reset = 1'b0;
    #1;
    chk("fetch_memreq", 32'(MemReq), 1);
    chk("fetch_irwrite", 32'(IRWrite), 1);
    chk("fetch_srcb", 32'(ALUSrcB), 2);
    chk("fetch_result", 32'(ResultSrc), 2);

    // lw: FETCH, DECODE, MEMADR, MEMREAD, MEMWB
    for (int i = 0; i < 5; i++) begin
      chk("lw_state", 32'(State), 32'(i));
      chk("lw_regwrite", 32'(RegWrite), (i == 4) ? 1 : 0);
      chk("lw_irwrite", 32'(IRWrite), (i == 0) ? 1 : 0);
      if (i == 1) chk("lw_immsrc", 32'(ImmSrc), 0);
      if (i == 3) chk("lw_memread_adr", 32'({MemReq, AdrSrc}), 3);
      if (i == 4) chk("lw_memwb_result", 32'(ResultSrc), 1);
      tick();
    end
    chk("lw_done", 32'(State), 0);

    // FETCH waits while memory is not ready.
    MemReady = 1'b0;
    #1;
    chk("fwait_memreq", 32'(MemReq), 1);
    chk("fwait_en", 32'({IRWrite, PCWrite}), 0);
    tick();
    chk("fwait_state", 32'(State), 0);

    // sw with two wait cycles in MEMWRITE.
    op       = 7'b0100011;
    MemReady = 1'b1;
    tick();
    chk("sw_dec_state", 32'(State), 1);
    chk("sw_dec_immsrc", 32'(ImmSrc), 1);
    chk("sw_dec_srcs", 32'({ALUSrcA, ALUSrcB}), 32'(4'b0101));
    tick();
    chk("sw_madr_state", 32'(State), 2);
    chk("sw_madr_srcs", 32'({ALUSrcA, ALUSrcB}), 32'(4'b1001));
    tick();
    for (int i = 0; i < 3; i++) begin
      MemReady = (i == 2);
      #1;
      chk("sw_mw_state", 32'(State), 5);
      chk("sw_mw_memwrite", 32'(MemWrite), 1);
      chk("sw_mw_memreq", 32'(MemReq), 1);
      chk("sw_mw_adrsrc", 32'(AdrSrc), 1);
      tick();
    end
    chk("sw_done", 32'(State), 0);

    // beq taken then not taken.
    op   = 7'b1100011;
    Zero = 1'b1;
    tick();
    chk("beq1_immsrc", 32'(ImmSrc), 2);
    tick();
    chk("beq1_state", 32'(State), 9);
    chk("beq1_pcwrite", 32'(PCWrite), 1);
    chk("beq1_aluctl", 32'(ALUControl), 1);
    tick();
    chk("beq1_done", 32'(State), 0);
    Zero = 1'b0;
    tick();
    tick();
    chk("beq2_state", 32'(State), 9);
    chk("beq2_pcwrite", 32'(PCWrite), 0);
    tick();
    chk("beq2_done", 32'(State), 0);

    // R-type sub, then walk funct3 through the other ALU ops.
    op     = 7'b0110011;
    funct3 = 3'b000;
    funct7 = 7'b0100000;
    tick();
    tick();
    chk("r_state", 32'(State), 6);
    chk("r_sub", 32'(ALUControl), 1);
    chk("r_srcs", 32'({ALUSrcA, ALUSrcB}), 32'(4'b1000));
    funct3 = 3'b111; #1; chk("r_and", 32'(ALUControl), 2);
    funct3 = 3'b110; #1; chk("r_or", 32'(ALUControl), 3);
    funct3 = 3'b010; #1; chk("r_slt", 32'(ALUControl), 5);
    funct3 = 3'b001; #1; chk("r_other", 32'(ALUControl), 0);
    funct3 = 3'b000; funct7 = 7'b0000000; #1; chk("r_add", 32'(ALUControl), 0);
    tick();
    chk("r_wb_state", 32'(State), 8);
    chk("r_wb_regwrite", 32'(RegWrite), 1);
    chk("r_wb_result", 32'(ResultSrc), 0);
    tick();
    chk("r_done", 32'(State), 0);

    // addi with funct7 pattern that would mean sub for R-type.
    op     = 7'b0010011;
    funct7 = 7'b0100000;
    tick();
    tick();
    chk("i_state", 32'(State), 7);
    chk("i_add", 32'(ALUControl), 0);
    chk("i_srcb", 32'(ALUSrcB), 1);
    tick();
    tick();
    chk("i_done", 32'(State), 0);

    // jal
    op     = 7'b1101111;
    funct7 = 7'b0000000;
    tick();
    chk("jal_immsrc", 32'(ImmSrc), 3);
    tick();
    chk("jal_state", 32'(State), 10);
    chk("jal_pcwrite", 32'(PCWrite), 1);
    chk("jal_srcs", 32'({ALUSrcA, ALUSrcB}), 32'(4'b0110));
    tick();
    chk("jal_wb_state", 32'(State), 8);
    chk("jal_wb_regwrite", 32'(RegWrite), 1);
    tick();
    chk("jal_done", 32'(State), 0);

    // Illegal opcode traps and stays.
    op = 7'b1111111;
    tick();
    tick();
    for (int i = 0; i < 12; i++) begin
      chk("trap_state", 32'(State), 11);
      chk("trap_flag", 32'(Trap), 1);
      chk("trap_en", 32'({PCWrite, IRWrite, MemWrite, RegWrite, MemReq}), 0);
      tick();
    end
    reset = 1'b1;
    tick();
    chk("trap_rst_state", 32'(State), 0);
    chk("trap_rst_flag", 32'(Trap), 0);
    reset = 1'b0;

    // Reset during a stalled MEMWRITE.
    op = 7'b0100011;
    tick();
    tick();
    tick();
    MemReady = 1'b0;
    #1;
    chk("rmw_memwrite_pre", 32'(MemWrite), 1);
    reset = 1'b1;
    #1;
    chk("rmw_memwrite_rst", 32'(MemWrite), 0);
    chk("rmw_memreq_rst", 32'(MemReq), 0);
    tick();
    reset = 1'b0;
    #1;
    chk("rmw_state", 32'(State), 0);
    chk("rmw_no_writes", 32'({PCWrite, RegWrite, MemWrite, IRWrite}), 0);
    tick();
    chk("rmw_hold", 32'(State), 0);
    MemReady = 1'b1;
    #1;
    chk("rmw_refetch", 32'(IRWrite), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
